// File: rtl/pc_hazard_pkg.sv
// ---------------------------------------------------------------------------
// pc_hazard_pkg
//   Shared definitions for the PC / hazard control slice: FSM state
//   encodings, the sequential PC increment, the hard-wired zero register
//   index and a saturating increment helper for the optional statistics
//   counters (enabled with HAZARD_STATS_EN).
// ---------------------------------------------------------------------------
package pc_hazard_pkg;

  // Hazard controller states. FLUSH is the single cycle after a taken
  // branch, during which EX holds a bubble and its fields are meaningless.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_e;

  // Byte distance between consecutive instructions.
  localparam int unsigned PC_INCR  = 4;

  // Architectural $0: a load into it never creates a dependency.
  localparam int unsigned ZERO_REG = 0;

  // Width and ceiling of the statistics counters.
  localparam int unsigned CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Increment that sticks at the ceiling instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage : pc_hazard_pkg

// File: rtl/pc_hazard_detect.sv
// ---------------------------------------------------------------------------
// pc_hazard_detect
//   Purely combinational load-use hazard detector. Flags when the load
//   currently in EX writes a register that the instruction in ID reads.
//
//   Ports:
//     id_rs       in  REG_W  source reg 1 of the ID instruction
//     id_rt       in  REG_W  source reg 2 of the ID instruction
//     id_uses_rt  in  1      ID instruction actually reads id_rt
//     ex_mem_read in  1      EX instruction is a load
//     ex_rt       in  REG_W  destination of the load in EX
//     lu          out 1      load-use hazard present
// ---------------------------------------------------------------------------
module pc_hazard_detect
  import pc_hazard_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  output logic             lu
);

  logic dest_live;
  logic rs_match;
  logic rt_match;

  // A load into $0 is discarded by the register file, so no consumer can
  // depend on it.
  assign dest_live = ex_mem_read && (ex_rt != REG_W'(ZERO_REG));
  assign rs_match  = (ex_rt == id_rs);
  // id_rt only matters when the ID instruction reads it (e.g. not for
  // immediate-form ALU ops, where the rt field is a destination).
  assign rt_match  = id_uses_rt && (ex_rt == id_rt);

  assign lu = dest_live && (rs_match || rt_match);

endmodule : pc_hazard_detect

// File: rtl/pc_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pc_hazard_ctrl
//   Program counter and hazard control for the IF stage. Holds the PC
//   register, drives both candidate next-PC values of the 2-to-1 PC mux
//   and its select, and produces the load-use stall and branch-flush
//   controls for the IF/ID and ID/EX pipeline registers.
//
//   Optional feature: define HAZARD_STATS_EN to add saturating 16-bit
//   stall/flush event counters and their output ports.
//
//   Parameters:
//     ADDR_W    PC and branch-target width
//     REG_W     register-specifier width
//     RESET_PC  PC value held during reset
//
//   Ports:
//     clk, rst_n          clock (rising edge), async active-low reset
//     id_rs, id_rt        source registers of the ID instruction
//     id_uses_rt          ID instruction reads id_rt
//     ex_mem_read, ex_rt  EX instruction is a load, and its destination
//     ex_branch_taken     branch in EX resolved taken
//     ex_branch_target    branch target from EX
//     pc                  current fetch PC (registered)
//     pc_next_0           pc + 4            (mux input 0)
//     pc_next_1           word-aligned target (mux input 1)
//     pc_src              mux select, 1 = branch target
//     pc_write            PC register enable
//     ifid_write          IF/ID register enable
//     ifid_flush          clear IF/ID to NOP
//     idex_bubble         insert NOP into ID/EX
//     stall_cnt, flush_cnt  event counters (HAZARD_STATS_EN only)
// ---------------------------------------------------------------------------
module pc_hazard_ctrl
  import pc_hazard_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        REG_W    = 5,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_mem_read,
  input  logic [REG_W-1:0]  ex_rt,
  input  logic              ex_branch_taken,
  input  logic [ADDR_W-1:0] ex_branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next_0,
  output logic [ADDR_W-1:0] pc_next_1,
  output logic              pc_src,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  hz_state_e         state_q;
  hz_state_e         state_d;
  logic [ADDR_W-1:0] pc_q;
  logic              lu_raw;
  logic              hz_eval;
  logic              br;
  logic              lu;
  logic              unused_tgt_lsbs;

  // -------------------------------------------------------------------------
  // Hazard qualification
  // -------------------------------------------------------------------------
  pc_hazard_detect #(
    .REG_W (REG_W)
  ) u_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .lu          (lu_raw)
  );

  // In FLUSH, EX holds the bubble inserted by the branch, so every ex_*
  // input is stale and must not trigger another redirect or stall.
  assign hz_eval = (state_q != ST_FLUSH);
  // Branch wins over load-use: the stalled instruction is squashed anyway.
  assign br      = hz_eval && ex_branch_taken;
  assign lu      = hz_eval && lu_raw && !br;

  // -------------------------------------------------------------------------
  // Next-PC candidates (modulo 2^ADDR_W)
  // -------------------------------------------------------------------------
  assign pc_next_0 = pc_q + ADDR_W'(PC_INCR);
  assign pc_next_1 = {ex_branch_target[ADDR_W-1:2], 2'b00};
  assign pc        = pc_q;

  // Target low bits are forced to zero; fold them into a named sink.
  assign unused_tgt_lsbs = ^ex_branch_target[1:0];

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = ST_RUN;
    unique case (state_q)
      ST_RUN, ST_STALL: begin
        // STALL lasts one cycle and then re-evaluates exactly like RUN;
        // a second load-use simply stalls again.
        if (br) begin
          state_d = ST_FLUSH;
        end else if (lu) begin
          state_d = ST_STALL;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    // Free-running fetch; also what FLUSH drives.
    pc_src      = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (br) begin
      // Redirect fetch and squash the two younger instructions in IF and ID.
      pc_src      = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu) begin
      // Freeze IF and ID for one cycle while the load reaches MEM.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // PC register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (pc_write) begin
      pc_q <= pc_src ? pc_next_1 : pc_next_0;
    end
  end

`ifdef HAZARD_STATS_EN
  // -------------------------------------------------------------------------
  // Event counters: one count per edge on which a stall or a redirect is
  // actually taken (never in FLUSH, and a branch masks a coincident stall).
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (lu) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (br) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule : pc_hazard_ctrl
